// File: rtl/gf_operand_bridge.sv
// Register bridge between a 32-bit write/read port and a GF(2^163) multiplier core.
// Sequences clear/start/capture of the multiplier and flags a timeout if it never finishes.
module gf_operand_bridge #(
  parameter int TIMEOUT = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [3:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         go,
  output logic         busy,
  output logic         res_valid,
  output logic         err,
  input  logic [2:0]   rd_addr,
  output logic [31:0]  rd_data,
  output logic         mul_rst,
  output logic         mul_start,
  output logic [162:0] mul_a,
  output logic [162:0] mul_b,
  input  logic [162:0] mul_z,
  input  logic         mul_done
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    RUN
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [162:0]       a_q, a_d;
  logic [162:0]       b_q, b_d;
  logic [162:0]       res_q, res_d;
  logic               res_valid_q, res_valid_d;
  logic               err_q, err_d;
  logic               timeout;
  logic [191:0]       res_ext;

  // Word k occupies bits [32k+31:32k]; word 5 keeps only the low 3 data bits.
  function automatic logic [162:0] put_word(input logic [162:0] v,
                                            input logic [2:0]   k,
                                            input logic [31:0]  d);
    logic [191:0] w;
    w = {29'b0, v};
    w[{k, 5'b0} +: 32] = d;
    return w[162:0];
  endfunction

  // The counter holds the number of RUN cycles already spent, so RUN lasts at most TIMEOUT cycles.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

  // NOTE: synchronous reset with non-blocking assignments only; operand and result
  // registers are plain flops and are cleared too, so rd_data/mul_a/mul_b read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = CLR;
      CLR:     state_d = RUN;
      RUN:     if (mul_done || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (wr_en && (wr_addr[2:0] < 3'd6)) begin
          if (wr_addr[3]) b_d = put_word(b_q, wr_addr[2:0], wr_data);
          else            a_d = put_word(a_q, wr_addr[2:0], wr_data);
        end
        if (go) begin
          res_valid_d = 1'b0;
          err_d       = 1'b0;
          cnt_d       = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A completion in the timeout cycle still counts as success.
        if (mul_done) begin
          res_d       = mul_z;
          res_valid_d = 1'b1;
        end else if (timeout) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    mul_rst   = rst || (state_q == CLR);
    mul_start = (state_q == RUN);
  end

  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign res_valid = res_valid_q;
  assign err       = err_q;
  assign res_ext   = {29'b0, res_q};

  always_comb begin
    rd_data = '0;
    if (rd_addr < 3'd6) rd_data = res_ext[{rd_addr, 5'b0} +: 32];
  end

endmodule

// File: tb/tb_gf_operand_bridge.sv
// Bench for gf_operand_bridge: reference GF(2^163) multiplier, transaction-level model
// compared every cycle, directed literal cases and a randomized traffic phase.
module tb_gf_operand_bridge;

  localparam int MAIN_TO  = 200;
  localparam int SHORT_TO = 20;
  localparam logic [162:0] POLY_LOW = 163'hC9;

  logic         clk = 1'b0;
  logic         rst, wr_en, go, go2, force_done, mult_en;
  logic [3:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [2:0]   rd_addr;
  logic         busy, res_valid, err, mul_rst, mul_start;
  logic [31:0]  rd_data;
  logic [162:0] mul_a, mul_b;
  logic [162:0] mul_z = '0;
  logic         mdone = 1'b0;
  wire          mul_done;

  logic         busy2, res_valid2, err2, mul_rst2, mul_start2;
  logic [31:0]  rd_data2;
  logic [162:0] mul_a2, mul_b2;
  logic [162:0] zero163 = '0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  int lat      = 3;

  assign mul_done = mdone | force_done;

  always #5 clk = ~clk;

  gf_operand_bridge dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .go(go), .busy(busy), .res_valid(res_valid), .err(err),
    .rd_addr(rd_addr), .rd_data(rd_data), .mul_rst(mul_rst), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z), .mul_done(mul_done)
  );

  gf_operand_bridge #(.TIMEOUT(SHORT_TO)) dut_to (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .go(go2), .busy(busy2), .res_valid(res_valid2), .err(err2),
    .rd_addr(rd_addr), .rd_data(rd_data2), .mul_rst(mul_rst2), .mul_start(mul_start2),
    .mul_a(mul_a2), .mul_b(mul_b2), .mul_z(zero163), .mul_done(1'b0)
  );

  // Polynomial product modulo x^163 + x^7 + x^6 + x^3 + 1 (Horner over b's bits).
  function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b);
    logic [162:0] r;
    r = '0;
    for (int i = 162; i >= 0; i--) begin
      r = r[162] ? ((r << 1) ^ POLY_LOW) : (r << 1);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [162:0] set_word(input logic [162:0] v, input int k,
                                            input logic [31:0] d);
    for (int i = 0; i < 32; i++)
      if (32 * k + i < 163) v[32 * k + i] = d[i];
    return v;
  endfunction

  function automatic logic [31:0] word_of(input logic [162:0] v, input int k);
    logic [31:0] w;
    w = '0;
    if (k < 6)
      for (int i = 0; i < 32; i++)
        if (32 * k + i < 163) w[i] = v[32 * k + i];
    return w;
  endfunction

  task automatic check(input string name, input logic [162:0] act, input logic [162:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference multiplier: cleared by mul_rst, pulses done lat cycles after start rises.
  int mcnt  = 0;
  bit fired = 1'b0;
  always @(negedge clk) begin
    mdone = 1'b0;
    if (mul_rst) begin
      mcnt  = 0;
      fired = 1'b0;
    end else if (mul_start && mult_en && !fired) begin
      mcnt++;
      if (mcnt >= lat) begin
        mdone = 1'b1;
        fired = 1'b1;
        mul_z = gf_mul(mul_a, mul_b);
      end
    end
  end

  // Transaction model: phase 0 idle, 1 clear, 2 running; m_runs counts RUN cycles spent.
  int           m_phase = 0;
  int           m_runs  = 0;
  logic [162:0] m_a = '0, m_b = '0, m_res = '0;
  bit           m_valid = 1'b0, m_err = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_runs = 0; m_a = '0; m_b = '0; m_res = '0;
      m_valid = 1'b0; m_err = 1'b0;
    end else if (m_phase == 0) begin
      if (wr_en && (int'(wr_addr[2:0]) < 6)) begin
        if (wr_addr[3]) m_b = set_word(m_b, int'(wr_addr[2:0]), wr_data);
        else            m_a = set_word(m_a, int'(wr_addr[2:0]), wr_data);
      end
      if (go) begin
        m_phase = 1; m_valid = 1'b0; m_err = 1'b0;
      end
    end else if (m_phase == 1) begin
      m_phase = 2; m_runs = 0;
    end else begin
      m_runs++;
      if (mul_done) begin
        m_res = gf_mul(m_a, m_b); m_valid = 1'b1; m_phase = 0;
      end else if (m_runs == MAIN_TO) begin
        m_err = 1'b1; m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_phase != 0);
      check("res_valid", res_valid, m_valid);
      check("err", err, m_err);
      check("mul_rst", mul_rst, rst || (m_phase == 1));
      check("mul_start", mul_start, m_phase == 2);
      check("mul_a", mul_a, m_a);
      check("mul_b", mul_b, m_b);
      check("rd_data", rd_data, word_of(m_res, int'(rd_addr)));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d, input logic g);
    wr_en = 1'b1; wr_addr = a; wr_data = d; go = g;
    step();
    wr_en = 1'b0; go = 1'b0;
  endtask

  task automatic rd_check(input logic [2:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    check($sformatf("rd_word%0d", a), rd_data, exp);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      step();
      i++;
    end
    check("wait_idle", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [162:0] a_exp;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0; go2 = 1'b0;
    force_done = 1'b0; mult_en = 1'b1; rd_addr = '0;
    step(); step();

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_mul_start", mul_start, 1'b0);
    check("rst_mul_rst", mul_rst, 1'b1);
    check("rst_mul_a", mul_a, '0);
    check("rst_rd_data", rd_data, '0);
    rst = 1'b0; chk_en = 1'b1;
    step();
    check("rel_mul_rst", mul_rst, 1'b0);

    // 1 * x = x
    write(4'd0, 32'h1, 1'b0);
    write(4'd8, 32'h2, 1'b0);
    lat = 4;
    go = 1'b1; step(); go = 1'b0;
    check("clr_mul_rst", mul_rst, 1'b1);
    wait_idle(50);
    check("p1_res_valid", res_valid, 1'b1);
    rd_check(3'd0, 32'h2);
    for (int k = 1; k < 6; k++) rd_check(3'(k), 32'h0);
    rd_check(3'd6, 32'h0);

    // x^162 * x reduces to 0xC9; upper bits of word 5 data are dropped
    write(4'd0, 32'h0, 1'b0);
    write(4'd5, 32'hFFFF_FFFC, 1'b0);
    go = 1'b1; step(); go = 1'b0;
    wait_idle(50);
    rd_check(3'd0, 32'hC9);
    for (int k = 1; k < 6; k++) rd_check(3'(k), 32'h0);

    // Back-to-back: write B0=3 together with go, result flag drops at once
    check("b2b_prev_valid", res_valid, 1'b1);
    lat = 6;
    write(4'd8, 32'h3, 1'b1);
    check("b2b_valid_drop", res_valid, 1'b0);
    check("b2b_busy", busy, 1'b1);
    wait_idle(50);
    check("b2b_res_valid", res_valid, 1'b1);
    rd_check(3'd0, 32'hC9);
    rd_check(3'd1, 32'h0);
    rd_check(3'd5, 32'h4);

    // Writes and go during RUN are ignored
    lat = 30;
    go = 1'b1; step(); go = 1'b0;
    for (int i = 0; i < 5; i++) step();
    write(4'd0, 32'h1234, 1'b1);
    write(4'd13, 32'h7, 1'b1);
    a_exp = '0;
    a_exp[162] = 1'b1;
    check("run_mul_a", mul_a, a_exp);
    check("run_mul_b", mul_b, 163'd3);
    wait_idle(60);
    rd_check(3'd0, 32'hC9);
    rd_check(3'd5, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_second_op", busy, 1'b0);
    end

    // Reset 50 cycles into RUN aborts; a late done is not captured
    mult_en = 1'b0;
    go = 1'b1; step(); go = 1'b0;
    step();
    for (int i = 0; i < 49; i++) step();
    check("abort_busy_before", busy, 1'b1);
    rst = 1'b1; step();
    check("abort_busy", busy, 1'b0);
    check("abort_res_valid", res_valid, 1'b0);
    check("abort_err", err, 1'b0);
    check("abort_mul_start", mul_start, 1'b0);
    check("abort_mul_a", mul_a, '0);
    check("abort_mul_b", mul_b, '0);
    rd_check(3'd0, 32'h0);
    rd_check(3'd5, 32'h0);
    rst = 1'b0; step();
    force_done = 1'b1; step(); force_done = 1'b0;
    step();
    check("late_done_valid", res_valid, 1'b0);
    check("late_done_busy", busy, 1'b0);
    rd_check(3'd0, 32'h0);
    mult_en = 1'b1;

    // Timeout instance: done never arrives
    go2 = 1'b1; step(); go2 = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("to_busy_21", busy2, 1'b1);
    check("to_err_21", err2, 1'b0);
    step();
    check("to_busy_22", busy2, 1'b0);
    check("to_err_22", err2, 1'b1);
    check("to_res_valid", res_valid2, 1'b0);
    check("to_mul_start", mul_start2, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 399) == 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      rd_addr = 3'($urandom_range(0, 7));
      if (m_phase == 0) begin
        go = ($urandom_range(0, 5) == 0);
        if (go) lat = $urandom_range(1, 12);
      end else begin
        go = ($urandom_range(0, 3) == 0);
      end
      force_done = (m_phase != 2) && ($urandom_range(0, 7) == 0);
      step();
    end
    rst = 1'b0; wr_en = 1'b0; go = 1'b0; force_done = 1'b0;
    step();
    wait_idle(50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gf_operand_bridge.md
GF_OPERAND_BRIDGE -- requirements
Module: gf_operand_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 200, meaning the maximum number of RUN cycles to wait for mul_done before flagging an error.
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port wr_en, input, 1, operand word write strobe.
REQ-005 SHALL have port wr_addr, input, 4, operand word select: 0-5 = A words 0-5, 8-13 = B words 0-5; other values are ignored.
REQ-006 SHALL have port wr_data, input, 32, operand write data.
REQ-007 SHALL have port go, input, 1, request one GF(2^163) multiplication.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port res_valid, output, 1, result register holds a completed product.
REQ-010 SHALL have port err, output, 1, last operation timed out.
REQ-011 SHALL have port rd_addr, input, 3, result word select, 0-5.
REQ-012 SHALL have port rd_data, output, 32, result word; combinational from rd_addr; 0 for rd_addr 6-7.
REQ-013 SHALL have port mul_rst, output, 1, multiplier reset.
REQ-014 SHALL have port mul_start, output, 1, multiplier start level.
REQ-015 SHALL have ports mul_a and mul_b, output, 163, multiplier operands, driven directly from the operand registers.
REQ-016 SHALL have port mul_z, input, 163, multiplier product.
REQ-017 SHALL have port mul_done, input, 1, multiplier one-cycle completion pulse.

Function
REQ-018 SHALL map word k to bits [32k+31:32k]; word 5 SHALL use only wr_data[2:0] for bits 162:160, and rd_data word 5 SHALL be zero-extended.
REQ-019 SHALL implement FSM states IDLE, CLR, RUN.
REQ-020 In IDLE, a write SHALL update the addressed operand word; in CLR or RUN, writes SHALL be ignored.
REQ-021 In IDLE with go=1, the FSM SHALL move to CLR next cycle, clear res_valid and err, and set busy.
REQ-022 A write and go in the same IDLE cycle SHALL both take effect, and the written word SHALL be included in the operation.
REQ-023 go SHALL be ignored in CLR and RUN, and SHALL NOT be queued.
REQ-024 CLR SHALL last exactly 1 cycle with mul_rst=1 and mul_start=0, then move to RUN.
REQ-025 RUN SHALL hold mul_start=1 and mul_rst=0, and SHALL increment a wait counter cleared on entry to CLR.
REQ-026 In RUN with mul_done=1, the block SHALL capture mul_z into the result register, set res_valid=1, drop mul_start, and return to IDLE next cycle.
REQ-027 In RUN, if the counter reaches TIMEOUT without mul_done, the block SHALL set err=1, leave res_valid=0, drop mul_start, and return to IDLE.
REQ-028 If mul_done and timeout occur in the same cycle, mul_done SHALL win.
REQ-029 mul_done SHALL be ignored outside RUN.
REQ-030 busy SHALL be 1 exactly in CLR and RUN.
REQ-031 The result register SHALL hold its value until the next successful capture.
REQ-032 Latency from go to res_valid SHALL be 2 cycles plus the multiplier's start-to-done latency.

Reset
REQ-033 On rst, state SHALL be IDLE, and busy, res_valid, err, mul_start, counter, operand registers and result register SHALL be 0.
REQ-034 During rst, mul_rst SHALL be 1.
REQ-035 rst mid-operation SHALL abort immediately, with no capture and no err.

Verification
REQ-036 Bench SHALL cover: write A word0=1, B word0=2, go -> with reference multiplier attached, res_valid=1 and rd_data word0=0x00000002, words 1-5=0.
REQ-037 Bench SHALL cover: A word5=0x4 (x^162), B word0=0x2, go -> word0=0x000000C9, others 0 (reduction by x^163+x^7+x^6+x^3+1).
REQ-038 Bench SHALL cover: two back-to-back operations -> the second completes correctly (CLR reset observed), and res_valid drops the cycle after the second go.
REQ-039 Bench SHALL cover: mul_done tied 0, TIMEOUT=20 -> err=1 and busy=0 after 22 cycles from go, res_valid=0.
REQ-040 Bench SHALL cover: writes and go issued during RUN -> operands unchanged, no second operation started.
REQ-041 Bench SHALL cover: rst asserted 50 cycles into RUN -> all outputs 0 next cycle, and no capture on a later mul_done.
